program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: receives a little-endian length-prefixed byte
// image and writes it into instruction memory one halfword at a time.
module program_loader #(
   parameter int               HALF_WORD      = 16,
   parameter int               WORD           = 32,
   parameter int               MAX_HALF_WORDS = 256,
   parameter logic [WORD-1:0]  BASE_ADDR      = '0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_i,
   output logic                  byte_ready_o,
   output logic                  program_mem_write_en_o,
   output logic [HALF_WORD-1:0]  instruction_o,
   output logic [WORD-1:0]       instruction_addr_o,
   output logic                  cpu_reset_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [15:0]           count_o
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA_LO,
      DATA_HI,
      WRITE,
      DONE,
      ERROR
   } state_t;

   // Widened by one bit so the upper bound compares cleanly against 16-bit lengths.
   localparam logic [16:0] MAX_LEN = 17'(MAX_HALF_WORDS);

   state_t      state;
   state_t      state_next;
   logic [7:0]  len_lo;
   logic [15:0] length;
   logic [15:0] rx_len;
   logic        xfer;
   logic        len_bad;
   logic        last;

   assign xfer    = byte_valid_i && byte_ready_o;
   assign rx_len  = {byte_i, len_lo};
   assign len_bad = (rx_len == 16'd0) || ({1'b0, rx_len} > MAX_LEN);
   assign last    = (count_o + 16'd1) == length;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next             = state;
      byte_ready_o           = 1'b0;
      program_mem_write_en_o = 1'b0;
      cpu_reset_o            = 1'b1;
      done_o                 = 1'b0;
      error_o                = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_next = LEN_LO;
         end
         LEN_LO: begin
            byte_ready_o = 1'b1;
            if (xfer) state_next = LEN_HI;
         end
         LEN_HI: begin
            byte_ready_o = 1'b1;
            if (xfer) state_next = len_bad ? ERROR : DATA_LO;
         end
         DATA_LO: begin
            byte_ready_o = 1'b1;
            if (xfer) state_next = DATA_HI;
         end
         DATA_HI: begin
            byte_ready_o = 1'b1;
            if (xfer) state_next = WRITE;
         end
         WRITE: begin
            program_mem_write_en_o = 1'b1;
            state_next             = last ? DONE : DATA_LO;
         end
         DONE: begin
            cpu_reset_o = 1'b0;
            done_o      = 1'b1;
            if (start_i) state_next = LEN_LO;
         end
         ERROR: begin
            error_o = 1'b1;
            if (start_i) state_next = LEN_LO;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Address and count advance as WRITE is left, so both stay stable during the strobe.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         len_lo             <= '0;
         length             <= '0;
         instruction_o      <= '0;
         instruction_addr_o <= BASE_ADDR;
         count_o            <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start_i) begin
                  count_o            <= '0;
                  instruction_addr_o <= BASE_ADDR;
               end
            end
            LEN_LO: begin
               if (xfer) len_lo <= byte_i;
            end
            LEN_HI: begin
               if (xfer) length <= rx_len;
            end
            DATA_LO: begin
               if (xfer) instruction_o[7:0] <= byte_i;
            end
            DATA_HI: begin
               if (xfer) instruction_o[15:8] <= byte_i;
            end
            WRITE: begin
               count_o            <= count_o + 16'd1;
               instruction_addr_o <= instruction_addr_o + WORD'(2);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a stream-level model predicts every write,
// and a negedge monitor compares each strobe and status output against it.
module tb_program_loader;

   localparam int              HW   = 16;
   localparam int              W    = 32;
   localparam int              MAXH = 256;
   localparam logic [W-1:0]    BASE = '0;

   typedef struct packed {
      logic [W-1:0]  addr;
      logic [HW-1:0] data;
   } wr_t;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic          byte_valid_i;
   logic [7:0]    byte_i;
   logic          byte_ready_o;
   logic          program_mem_write_en_o;
   logic [HW-1:0] instruction_o;
   logic [W-1:0]  instruction_addr_o;
   logic          cpu_reset_o;
   logic          done_o;
   logic          error_o;
   logic [15:0]   count_o;

   wr_t           exp_q[$];
   logic [7:0]    stream[$];
   int            checks      = 0;
   int            failures    = 0;
   int            consumed    = 0;
   int            writes_seen = 0;
   int            exp_count   = 0;
   logic          exp_error   = 1'b0;
   logic          prev_we     = 1'b0;
   logic [HW-1:0] first_data  = '0;
   logic [W-1:0]  first_addr  = '0;
   logic [HW-1:0] last_data   = '0;
   logic [W-1:0]  last_addr   = '0;

   program_loader #(
      .HALF_WORD      (HW),
      .WORD           (W),
      .MAX_HALF_WORDS (MAXH),
      .BASE_ADDR      (BASE)
   ) dut (
      .clk_i                  (clk_i),
      .reset_i                (reset_i),
      .start_i                (start_i),
      .byte_valid_i           (byte_valid_i),
      .byte_i                 (byte_i),
      .byte_ready_o           (byte_ready_o),
      .program_mem_write_en_o (program_mem_write_en_o),
      .instruction_o          (instruction_o),
      .instruction_addr_o     (instruction_addr_o),
      .cpu_reset_o            (cpu_reset_o),
      .done_o                 (done_o),
      .error_o                (error_o),
      .count_o                (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // The model works on the whole byte stream: length prefix, then halfword pairs.
   task automatic build_model();
      int len;
      exp_q.delete();
      len       = {stream[1], stream[0]};
      exp_error = (len == 0) || (len > MAXH);
      exp_count = exp_error ? 0 : len;
      if (!exp_error) begin
         for (int i = 0; i < len; i++) begin
            exp_q.push_back('{addr: BASE + W'(2 * i), data: {stream[3 + 2 * i], stream[2 + 2 * i]}});
         end
      end
   endtask

   always @(negedge clk_i) begin
      wr_t w;
      check_output("cpu_reset_vs_done", cpu_reset_o, !done_o);
      check_output("done_error_exclusive", done_o & error_o, 0);
      check_output("count", count_o, consumed[15:0]);
      if (program_mem_write_en_o) begin
         check_output("strobe_width", prev_we, 0);
         check_output("ready_in_write", byte_ready_o, 0);
         if (exp_q.size() == 0) begin
            check_output("unexpected_strobe", program_mem_write_en_o, 0);
         end else begin
            w = exp_q.pop_front();
            check_output("write_data", instruction_o, w.data);
            check_output("write_addr", instruction_addr_o, w.addr);
            if (writes_seen == 0) begin
               first_data = instruction_o;
               first_addr = instruction_addr_o;
            end
            last_data = instruction_o;
            last_addr = instruction_addr_o;
            consumed++;
            writes_seen++;
         end
      end
      prev_we = program_mem_write_en_o;
   end

   task automatic check_reset_values();
      check_output("rst_ready", byte_ready_o, 0);
      check_output("rst_we", program_mem_write_en_o, 0);
      check_output("rst_instruction", instruction_o, 0);
      check_output("rst_addr", instruction_addr_o, BASE);
      check_output("rst_count", count_o, 0);
      check_output("rst_cpu_reset", cpu_reset_o, 1);
      check_output("rst_done", done_o, 0);
      check_output("rst_error", error_o, 0);
   endtask

   task automatic start_load();
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i     = 1'b0;
      consumed    = 0;
      writes_seen = 0;
      build_model();
      @(negedge clk_i);
      check_output("start_error_clear", error_o, 0);
      check_output("start_done_clear", done_o, 0);
      check_output("start_count_clear", count_o, 0);
      check_output("start_cpu_reset", cpu_reset_o, 1);
      check_output("start_ready", byte_ready_o, 1);
      @(posedge clk_i); #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic accepted;
      accepted     = 1'b0;
      byte_valid_i = 1'b0;
      repeat (gap) begin
         @(posedge clk_i); #1;
      end
      byte_valid_i = 1'b1;
      byte_i       = b;
      for (int tries = 0; tries < 50; tries++) begin
         @(negedge clk_i);
         if (byte_ready_o) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) check_output("byte_accept_timeout", byte_ready_o, 1);
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic wait_finish();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk_i);
         if (done_o || error_o) break;
      end
      check_output("finish_timeout", done_o | error_o, 1);
      check_output("end_error", error_o, exp_error);
      check_output("end_done", done_o, !exp_error);
      check_output("end_cpu_reset", cpu_reset_o, exp_error);
      check_output("end_count", count_o, exp_count[15:0]);
      check_output("writes_missing", exp_q.size(), 0);
      @(posedge clk_i); #1;
   endtask

   task automatic apply_stimulus(input int gap_max, input bit check_latency);
      start_load();
      foreach (stream[i]) begin
         send_byte(stream[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      end
      if (check_latency) begin
         @(negedge clk_i);
         check_output("write_latency", program_mem_write_en_o, 1);
         @(posedge clk_i); #1;
      end
      wait_finish();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_i      = 1'b1;
      start_i      = 1'b0;
      byte_valid_i = 1'b0;
      byte_i       = 8'h00;
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_values();
      reset_i = 1'b0;
      @(posedge clk_i); #1;

      $display("[TB] three-halfword load");
      stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      apply_stimulus(0, 1'b1);
      check_output("t1_writes", writes_seen, 3);
      check_output("t1_first_data", first_data, 16'h2211);
      check_output("t1_first_addr", first_addr, 0);
      check_output("t1_last_data", last_data, 16'h6655);
      check_output("t1_last_addr", last_addr, 4);
      check_output("t1_count", count_o, 3);
      check_output("t1_cpu_reset", cpu_reset_o, 0);

      $display("[TB] zero length");
      stream = '{8'h00, 8'h00};
      apply_stimulus(0, 1'b0);
      check_output("t2_error", error_o, 1);
      check_output("t2_cpu_reset", cpu_reset_o, 1);
      check_output("t2_writes", writes_seen, 0);

      $display("[TB] oversize length");
      stream = '{8'h01, 8'h01};
      apply_stimulus(0, 1'b0);
      check_output("t3_error", error_o, 1);
      check_output("t3_writes", writes_seen, 0);

      $display("[TB] stalled stream");
      stream = '{8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      apply_stimulus(4, 1'b0);
      check_output("t4_writes", writes_seen, 2);
      check_output("t4_first_data", first_data, 16'hB2A1);
      check_output("t4_last_data", last_data, 16'hD4C3);
      check_output("t4_last_addr", last_addr, 2);

      $display("[TB] reload from done");
      stream = '{8'h01, 8'h00, 8'hEF, 8'hBE};
      apply_stimulus(1, 1'b0);
      check_output("t5_last_data", last_data, 16'hBEEF);
      check_output("t5_last_addr", last_addr, 0);

      $display("[TB] reset mid-load");
      stream = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      start_load();
      for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
      @(negedge clk_i);
      check_output("t6_first_strobe", program_mem_write_en_o, 1);
      @(posedge clk_i); #1;
      reset_i  = 1'b1;
      exp_q.delete();
      consumed = 0;
      #1;
      check_reset_values();
      repeat (2) @(posedge clk_i);
      #1;
      reset_i      = 1'b0;
      byte_valid_i = 1'b1;
      byte_i       = 8'h01;
      repeat (4) begin
         @(negedge clk_i);
         check_output("t6_needs_start", byte_ready_o, 0);
      end
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
      stream = '{8'h01, 8'h00, 8'h34, 8'h12};
      apply_stimulus(0, 1'b0);
      check_output("t6_writes", writes_seen, 1);
      check_output("t6_data", last_data, 16'h1234);
      check_output("t6_addr", last_addr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
